// File: rtl/fft64_transpose_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft64_transpose_buf_if                                          |
// | Purpose  : Streaming bus bundle for the FFT64 corner-turn buffer.          |
// |            Carries the row-wise input stream and the column-wise output    |
// |            stream, both valid/ready handshaked.                            |
// | Signals  : din_valid/din_ready, dinre/dinim   - input beat (LANES lanes)   |
// |            dout_valid/dout_ready, doutre/doutim, dout_col, dout_sof        |
// |                                               - output beat + framing      |
// | Modports : master - producer/consumer side (testbench, neighbours)         |
// |            slave  - the transpose buffer itself                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface fft64_transpose_buf_if #(
  parameter int W     = 10,
  parameter int LANES = 8
);
  logic                       din_valid;
  logic                       din_ready;
  logic [LANES*W-1:0]         dinre;
  logic [LANES*W-1:0]         dinim;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [LANES*W-1:0]         doutre;
  logic [LANES*W-1:0]         doutim;
  logic [$clog2(LANES)-1:0]   dout_col;
  logic                       dout_sof;

  modport master (
    output din_valid, dinre, dinim, dout_ready,
    input  din_ready, dout_valid, doutre, doutim, dout_col, dout_sof
  );

  modport slave (
    input  din_valid, dinre, dinim, dout_ready,
    output din_ready, dout_valid, doutre, doutim, dout_col, dout_sof
  );
endinterface
`default_nettype wire

// File: rtl/fft64_transpose_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft64_transpose_buf                                             |
// | Purpose  : Ping-pong corner-turn buffer between the twiddle multiplier and |
// |            the second radix-8 stage of the 64-point FFT. Rows of an        |
// |            LANES x LANES frame are written one beat at a time into one     |
// |            bank while the other bank is read out column by column.         |
// | Ports    : clk        - single clock, rising edge                          |
// |            rst_n      - asynchronous active-low reset                      |
// |            bus.slave  - din_valid/din_ready/dinre/dinim (rows in)          |
// |                         dout_valid/dout_ready/doutre/doutim (columns out)  |
// |                         dout_col (column index), dout_sof (first column)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fft64_transpose_buf #(
  parameter int W     = 10,
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft64_transpose_buf_if.slave  bus
);

  localparam int                  c_IDXW = $clog2(LANES);
  localparam logic [c_IDXW-1:0]   c_LAST = c_IDXW'(LANES - 1);

  // Bank storage: [bank][row][col]. Contents are not reset.
  logic [W-1:0] r_mem_re [2][LANES][LANES];
  logic [W-1:0] r_mem_im [2][LANES][LANES];

  logic                 r_wr_bank;
  logic [c_IDXW-1:0]    r_wr_row;
  logic                 r_rd_bank;
  logic [c_IDXW-1:0]    r_rd_col;
  logic [1:0]           r_full;

  logic                 r_dout_valid;
  logic [LANES*W-1:0]   r_doutre;
  logic [LANES*W-1:0]   r_doutim;
  logic [c_IDXW-1:0]    r_dout_col;

  logic                 w_din_ready;
  logic                 w_wr_fire;
  logic                 w_rd_load;
  logic [1:0]           w_full_nxt;
  logic [LANES*W-1:0]   w_rd_re;
  logic [LANES*W-1:0]   w_rd_im;

  assign w_din_ready = !r_full[r_wr_bank];
  assign w_wr_fire   = bus.din_valid && w_din_ready;
  // The output register refills whenever it is empty or being drained.
  assign w_rd_load   = r_full[r_rd_bank] && (!r_dout_valid || bus.dout_ready);

  // Writer and reader always sit on different banks when both touch a full
  // flag in the same cycle, so set and clear never collide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_fire && (r_wr_row == c_LAST)) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_rd_load && (r_rd_col == c_LAST)) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  // Column gather: lane j of an output beat is row j of the selected column.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign w_rd_re[j*W +: W] = r_mem_re[r_rd_bank][j][r_rd_col];
    assign w_rd_im[j*W +: W] = r_mem_im[r_rd_bank][j][r_rd_col];
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int j = 0; j < LANES; j++) begin
        r_mem_re[r_wr_bank][r_wr_row][j] <= bus.dinre[j*W +: W];
        r_mem_im[r_wr_bank][r_wr_row][j] <= bus.dinim[j*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank    <= 1'b0;
      r_wr_row     <= '0;
      r_rd_bank    <= 1'b0;
      r_rd_col     <= '0;
      r_full       <= '0;
      r_dout_valid <= 1'b0;
      r_doutre     <= '0;
      r_doutim     <= '0;
      r_dout_col   <= '0;
    end else begin
      r_full <= w_full_nxt;

      if (w_wr_fire) begin
        if (r_wr_row == c_LAST) begin
          r_wr_row  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_row  <= r_wr_row + 1'b1;
        end
      end

      if (w_rd_load) begin
        r_doutre     <= w_rd_re;
        r_doutim     <= w_rd_im;
        r_dout_col   <= r_rd_col;
        r_dout_valid <= 1'b1;
        if (r_rd_col == c_LAST) begin
          r_rd_col  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_col  <= r_rd_col + 1'b1;
        end
      end else if (bus.dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign bus.din_ready  = w_din_ready;
  assign bus.dout_valid = r_dout_valid;
  assign bus.doutre     = r_doutre;
  assign bus.doutim     = r_doutim;
  assign bus.dout_col   = r_dout_col;
  assign bus.dout_sof   = r_dout_valid && (r_dout_col == '0);

endmodule
`default_nettype wire
